// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: runs one req/gnt/rvalid data-memory transaction per
// EX/MEM request, formats load data and holds the pipeline while the access is in flight.
module lsu_mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              fault_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic f_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic illegal;
        logic misal;
        if (we) illegal = (f3 > 3'd2);
        else    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        case (f3[1:0])
            2'b01:   misal = off[0];
            2'b10:   misal = (off != 2'b00);
            default: misal = 1'b0;
        endcase
        return illegal | misal;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return rd;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic               w_fault;
    logic               w_accept;
    logic               r_mem_req;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [ADDR_W-3:0]  r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [31:0]        r_load_data;
    logic               r_load_valid;
    logic               r_fault;

    assign w_fault  = f_fault(req_we_i, req_funct3_i, req_addr_i[1:0]);
    assign w_accept = (r_state == S_IDLE) && req_valid_i && !w_fault;

    // Stall while a legal request is being taken or the bus access is pending; never in reset.
    assign busy_o = rst_ni & (w_accept | (r_state == S_REQ) | (r_state == S_WAIT));

    // Next-state logic for the bus handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = S_REQ;  else w_next = S_IDLE;
            S_REQ:   if (mem_gnt_i)    w_next = S_WAIT; else w_next = S_REQ;
            S_WAIT:  if (mem_rvalid_i) w_next = S_DONE; else w_next = S_WAIT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, handshake pulses and latched request fields.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_fault      <= 1'b0;
            r_load_valid <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_off        <= 2'd0;
            r_addr       <= '0;
            r_be         <= 4'd0;
            r_wdata      <= 32'd0;
            r_load_data  <= 32'd0;
        end else begin
            r_state      <= w_next;
            r_mem_req    <= (w_next == S_REQ);
            r_fault      <= (r_state == S_IDLE) && req_valid_i && w_fault;
            r_load_valid <= (r_state == S_WAIT) && mem_rvalid_i && !r_we;
            if (w_accept) begin
                r_we     <= req_we_i;
                r_funct3 <= req_funct3_i;
                r_off    <= req_addr_i[1:0];
                r_addr   <= req_addr_i[ADDR_W-1:2];
                r_be     <= f_be(req_funct3_i, req_addr_i[1:0]);
                r_wdata  <= f_wdata(req_funct3_i, req_wdata_i);
            end
            // Stores complete without touching the last load result.
            if ((r_state == S_WAIT) && mem_rvalid_i && !r_we) begin
                r_load_data <= f_load(r_funct3, r_off, mem_rdata_i);
            end
        end
    end

    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_we;
    assign mem_be_o     = r_be;
    assign mem_addr_o   = {r_addr, 2'b00};
    assign mem_wdata_o  = r_wdata;
    assign load_data_o  = r_load_data;
    assign load_valid_o = r_load_valid;
    assign fault_o      = r_fault;

endmodule
